// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 16-bit pipelined MIPS core.
// Captures decoded operands/control, detects load-use hazards, forwards
// EX/MEM and MEM/WB results into the ALU operands, and counts stall cycles.
module id_ex_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_uses_rt,
  input  logic [OP_W-1:0]   id_alu_op,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              ex_flush,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              stall,
  output logic [DATA_W-1:0] Op1,
  output logic [DATA_W-1:0] Op2,
  output logic [OP_W-1:0]   ALUOperation,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_dest,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic [15:0]       stall_count
);

  // Registered pipeline state
  logic              valid_q, valid_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              mem_to_reg_q, mem_to_reg_d;
  logic              alu_src_q, alu_src_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [REG_AW-1:0] dest_q, dest_d;
  logic [REG_AW-1:0] rs_q, rs_d;
  logic [REG_AW-1:0] rt_q, rt_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [15:0]       stall_count_q, stall_count_d;

  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

  // Load-use hazard: the load in EX writes a register the ID instruction reads
  always_comb begin
    stall = id_valid & valid_q & mem_read_q & (dest_q != '0) &
            ((dest_q == id_rs) | (id_uses_rt & (dest_q == id_rt)));
  end

  // Next-state: flush beats stall beats normal capture; stalls are counted either way
  always_comb begin
    valid_d       = 1'b0;
    reg_write_d   = 1'b0;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    mem_to_reg_d  = 1'b0;
    alu_src_d     = 1'b0;
    alu_op_d      = '0;
    dest_d        = '0;
    rs_d          = '0;
    rt_d          = '0;
    rs_data_d     = '0;
    rt_data_d     = '0;
    imm_d         = '0;
    stall_count_d = stall_count_q;

    if (stall && stall_count_q != 16'hFFFF) begin
      stall_count_d = stall_count_q + 16'd1;
    end

    if (!ex_flush && !stall) begin
      valid_d      = id_valid;
      reg_write_d  = id_valid & id_reg_write;
      mem_read_d   = id_valid & id_mem_read;
      mem_write_d  = id_valid & id_mem_write;
      mem_to_reg_d = id_valid & id_mem_to_reg;
      alu_src_d    = id_alu_src;
      alu_op_d     = id_alu_op;
      dest_d       = id_reg_dst ? id_rd : id_rt;
      rs_d         = id_rs;
      rt_d         = id_rt;
      rs_data_d    = id_rs_data;
      rt_data_d    = id_rt_data;
      imm_d        = id_imm;
    end
  end

  // State register with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= 1'b0;
      reg_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      alu_src_q     <= 1'b0;
      alu_op_q      <= '0;
      dest_q        <= '0;
      rs_q          <= '0;
      rt_q          <= '0;
      rs_data_q     <= '0;
      rt_data_q     <= '0;
      imm_q         <= '0;
      stall_count_q <= '0;
    end else begin
      valid_q       <= valid_d;
      reg_write_q   <= reg_write_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_to_reg_q  <= mem_to_reg_d;
      alu_src_q     <= alu_src_d;
      alu_op_q      <= alu_op_d;
      dest_q        <= dest_d;
      rs_q          <= rs_d;
      rt_q          <= rt_d;
      rs_data_q     <= rs_data_d;
      rt_data_q     <= rt_data_d;
      imm_q         <= imm_d;
      stall_count_q <= stall_count_d;
    end
  end

  // Operand forwarding: youngest producer (EX/MEM) first, r0 never forwarded
  always_comb begin
    fwd_rs = rs_data_q;
    if (exmem_reg_write && exmem_rd != '0 && exmem_rd == rs_q) begin
      fwd_rs = exmem_result;
    end else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == rs_q) begin
      fwd_rs = memwb_result;
    end

    fwd_rt = rt_data_q;
    if (exmem_reg_write && exmem_rd != '0 && exmem_rd == rt_q) begin
      fwd_rt = exmem_result;
    end else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == rt_q) begin
      fwd_rt = memwb_result;
    end
  end

  // Output drive
  always_comb begin
    Op1           = fwd_rs;
    Op2           = alu_src_q ? imm_q : fwd_rt;
    ex_store_data = fwd_rt;
    ALUOperation  = alu_op_q;
    ex_dest       = dest_q;
    ex_valid      = valid_q;
    ex_reg_write  = reg_write_q;
    ex_mem_read   = mem_read_q;
    ex_mem_write  = mem_write_q;
    ex_mem_to_reg = mem_to_reg_q;
    stall_count   = stall_count_q;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for the ID/EX pipeline register.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [15:0] id_rs_data, id_rt_data, id_imm;
  logic [2:0]  id_rs, id_rt, id_rd;
  logic        id_uses_rt;
  logic [2:0]  id_alu_op;
  logic        id_alu_src, id_reg_dst;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        ex_flush;
  logic        exmem_reg_write;
  logic [2:0]  exmem_rd;
  logic [15:0] exmem_result;
  logic        memwb_reg_write;
  logic [2:0]  memwb_rd;
  logic [15:0] memwb_result;
  logic        stall;
  logic [15:0] Op1, Op2, ex_store_data;
  logic [2:0]  ALUOperation;
  logic [2:0]  ex_dest;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic [15:0] stall_count;

  int n_cmp = 0;
  int n_mis = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
    .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .ex_flush(ex_flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .stall(stall), .Op1(Op1), .Op2(Op2), .ALUOperation(ALUOperation),
    .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) begin
      $display("check %-14s observed=%h expected=%h ok", tag, obs, exp);
    end else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one decoded instruction on the ID inputs
  task automatic drive(input logic v, input logic [2:0] rs, input logic [2:0] rt,
                       input logic [2:0] rd, input logic [15:0] rsd, input logic [15:0] rtd,
                       input logic [15:0] imm, input logic urt, input logic [2:0] op,
                       input logic asrc, input logic rdst, input logic rw,
                       input logic mr, input logic mw, input logic m2r);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_uses_rt = urt;
    id_alu_op = op; id_alu_src = asrc; id_reg_dst = rdst;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r;
  endtask

  task automatic no_fwd();
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 16'h0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 16'h0;
  endtask

  initial begin
    rst_n = 0;
    ex_flush = 0;
    no_fwd();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("rst_valid", {15'd0, ex_valid}, 16'd0);
    chk("rst_aluop", {13'd0, ALUOperation}, 16'd0);
    rst_n = 1;

    // add r3,r1,r2 with r1=5, r2=7
    drive(1, 3'd1, 3'd2, 3'd3, 16'd5, 16'd7, 16'd0, 1, 3'b010, 0, 1, 1, 0, 0, 0);
    tick();
    chk("add_op1", Op1, 16'd5);
    chk("add_op2", Op2, 16'd7);
    chk("add_aluop", {13'd0, ALUOperation}, 16'd2);
    chk("add_dest", {13'd0, ex_dest}, 16'd3);
    chk("add_rw", {15'd0, ex_reg_write}, 16'd1);
    chk("add_stall", {15'd0, stall}, 16'd0);

    // add r6,r1,r2 with stale r1=0x99; exercise forwarding priorities
    drive(1, 3'd1, 3'd2, 3'd6, 16'h0099, 16'd7, 16'd0, 1, 3'b010, 0, 1, 1, 0, 0, 0);
    tick();
    exmem_reg_write = 1; exmem_rd = 3'd1; exmem_result = 16'h0011;
    memwb_reg_write = 1; memwb_rd = 3'd1; memwb_result = 16'h0022;
    #1 chk("fwd_both", Op1, 16'h0011);
    exmem_rd = 3'd0;
    #1 chk("fwd_exmem_r0", Op1, 16'h0022);
    memwb_rd = 3'd0;
    #1 chk("fwd_none", Op1, 16'h0099);
    exmem_rd = 3'd2;
    #1 chk("fwd_rt_op2", Op2, 16'h0011);
    chk("fwd_rt_op1", Op1, 16'h0099);
    exmem_reg_write = 0;
    #1 chk("fwd_rw_off", Op2, 16'd7);
    no_fwd();

    // lw r4,0(r1) then dependent sub r5,r4,r2
    drive(1, 3'd1, 3'd4, 3'd0, 16'h0100, 16'h0, 16'h0, 0, 3'b010, 1, 0, 1, 1, 0, 1);
    tick();
    chk("lw_mr", {15'd0, ex_mem_read}, 16'd1);
    chk("lw_dest", {13'd0, ex_dest}, 16'd4);
    chk("lw_op1", Op1, 16'h0100);
    drive(1, 3'd4, 3'd2, 3'd5, 16'hDEAD, 16'd7, 16'd0, 1, 3'b011, 0, 1, 1, 0, 0, 0);
    #1 chk("lu_stall", {15'd0, stall}, 16'd1);
    tick();
    chk("bub_valid", {15'd0, ex_valid}, 16'd0);
    chk("bub_rw", {15'd0, ex_reg_write}, 16'd0);
    chk("bub_aluop", {13'd0, ALUOperation}, 16'd0);
    chk("bub_count", stall_count, 16'd1);
    chk("bub_stall", {15'd0, stall}, 16'd0);
    tick();
    memwb_reg_write = 1; memwb_rd = 3'd4; memwb_result = 16'h1234;
    #1 chk("sub_op1", Op1, 16'h1234);
    chk("sub_op2", Op2, 16'd7);
    chk("sub_aluop", {13'd0, ALUOperation}, 16'd3);
    chk("sub_dest", {13'd0, ex_dest}, 16'd5);
    chk("sub_count", stall_count, 16'd1);
    no_fwd();

    // lw r4 then an instruction whose rt is r4: stall only if rt is a source
    drive(1, 3'd1, 3'd4, 3'd0, 16'h0100, 16'h0, 16'h0, 0, 3'b010, 1, 0, 1, 1, 0, 1);
    tick();
    drive(1, 3'd1, 3'd4, 3'd5, 16'd1, 16'd2, 16'd0, 0, 3'b000, 0, 1, 1, 0, 0, 0);
    #1 chk("urt0_stall", {15'd0, stall}, 16'd0);
    id_uses_rt = 1;
    #1 chk("urt1_stall", {15'd0, stall}, 16'd1);
    ex_flush = 1;
    tick();
    chk("fl_valid", {15'd0, ex_valid}, 16'd0);
    chk("fl_mr", {15'd0, ex_mem_read}, 16'd0);
    chk("fl_count", stall_count, 16'd2);
    // flush with no stall: bubble, counter unchanged
    tick();
    chk("fl2_valid", {15'd0, ex_valid}, 16'd0);
    chk("fl2_count", stall_count, 16'd2);
    ex_flush = 0;

    // sw r2,8(r1): Op2 = imm, store data forwarded from EX/MEM
    drive(1, 3'd1, 3'd2, 3'd0, 16'h0010, 16'h0055, 16'h0008, 1, 3'b010, 1, 0, 0, 0, 1, 0);
    tick();
    exmem_reg_write = 1; exmem_rd = 3'd2; exmem_result = 16'h0077;
    #1 chk("sw_op2", Op2, 16'h0008);
    chk("sw_store", ex_store_data, 16'h0077);
    chk("sw_op1", Op1, 16'h0010);
    chk("sw_mw", {15'd0, ex_mem_write}, 16'd1);
    no_fwd();

    // invalid instruction: control bits forced low
    drive(0, 3'd1, 3'd2, 3'd3, 16'd1, 16'd2, 16'd0, 1, 3'b010, 0, 1, 1, 1, 1, 1);
    tick();
    chk("inv_valid", {15'd0, ex_valid}, 16'd0);
    chk("inv_rw", {15'd0, ex_reg_write}, 16'd0);
    chk("inv_mr", {15'd0, ex_mem_read}, 16'd0);

    // saturation: preset counter to 0xFFFF, then load-use stall
    force dut.stall_count_q = 16'hFFFF;
    #1 release dut.stall_count_q;
    drive(1, 3'd1, 3'd4, 3'd0, 16'h0100, 16'h0, 16'h0, 0, 3'b010, 1, 0, 1, 1, 0, 1);
    tick();
    chk("sat_pre", stall_count, 16'hFFFF);
    drive(1, 3'd4, 3'd2, 3'd5, 16'h0, 16'd7, 16'd0, 1, 3'b011, 0, 1, 1, 0, 0, 0);
    #1 chk("sat_stall", {15'd0, stall}, 16'd1);
    tick();
    chk("sat_count", stall_count, 16'hFFFF);
    tick();
    chk("pre_rst_valid", {15'd0, ex_valid}, 16'd1);

    // mid-stream asynchronous reset, sampled with no clock edge
    #1 rst_n = 0;
    #1 chk("arst_valid", {15'd0, ex_valid}, 16'd0);
    chk("arst_aluop", {13'd0, ALUOperation}, 16'd0);
    chk("arst_count", stall_count, 16'd0);
    chk("arst_rw", {15'd0, ex_reg_write}, 16'd0);
    rst_n = 1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
